// File: rtl/bstream_gen.sv
// Two-channel unipolar stochastic bitstream encoder: one LFSR per channel, burst of len cycles.
// Optional per-channel ones counters are enabled by defining BSTREAM_GEN_ONES_CNT_EN.
module bstream_gen #(
   parameter int unsigned      WIDTH  = 8,
   parameter int unsigned      LEN_W  = 16,
   parameter logic [WIDTH-1:0] SEED_A = WIDTH'((WIDTH == 16) ? 32'hACE1 : 32'hA5),
   parameter logic [WIDTH-1:0] SEED_B = WIDTH'((WIDTH == 16) ? 32'h5EED : 32'h3C)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [WIDTH-1:0] val_a_i,
   input  logic [WIDTH-1:0] val_b_i,
   input  logic [LEN_W-1:0] len_i,
   output logic [1:0]       x_o,
   output logic             valid_o,
   output logic             busy_o,
   output logic             done_o
`ifdef BSTREAM_GEN_ONES_CNT_EN
   ,
   output logic [LEN_W-1:0] ones_a_o,
   output logic [LEN_W-1:0] ones_b_o
`endif
);

   // An all-zero seed would lock the LFSR, so it is promoted to 1.
   localparam logic [WIDTH-1:0] SeedA = (SEED_A == '0) ? WIDTH'(1) : SEED_A;
   localparam logic [WIDTH-1:0] SeedB = (SEED_B == '0) ? WIDTH'(1) : SEED_B;

   if ((WIDTH != 8) && (WIDTH != 16)) begin : gen_width_check
      $error("bstream_gen: WIDTH must be 8 or 16");
   end

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] lfsr_a_q, lfsr_a_d;
   logic [WIDTH-1:0] lfsr_b_q, lfsr_b_d;
   logic [WIDTH-1:0] val_a_q, val_a_d;
   logic [WIDTH-1:0] val_b_q, val_b_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             fb_a, fb_b;
   logic             bit_a, bit_b;

   if (WIDTH == 16) begin : gen_taps16
      assign fb_a = lfsr_a_q[15] ^ lfsr_a_q[14] ^ lfsr_a_q[12] ^ lfsr_a_q[3];
      assign fb_b = lfsr_b_q[15] ^ lfsr_b_q[14] ^ lfsr_b_q[12] ^ lfsr_b_q[3];
   end else begin : gen_taps8
      assign fb_a = lfsr_a_q[7] ^ lfsr_a_q[5] ^ lfsr_a_q[4] ^ lfsr_a_q[3];
      assign fb_b = lfsr_b_q[7] ^ lfsr_b_q[5] ^ lfsr_b_q[4] ^ lfsr_b_q[3];
   end

   assign bit_a = (lfsr_a_q <= val_a_q);
   assign bit_b = (lfsr_b_q <= val_b_q);

   always_comb begin
      state_d  = state_q;
      lfsr_a_d = lfsr_a_q;
      lfsr_b_d = lfsr_b_q;
      val_a_d  = val_a_q;
      val_b_d  = val_b_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               val_a_d  = val_a_i;
               val_b_d  = val_b_i;
               lfsr_a_d = SeedA;
               lfsr_b_d = SeedB;
               cnt_d    = len_i;
               state_d  = (len_i != '0) ? StRun : StDone;
            end
         end
         StRun: begin
            lfsr_a_d = {lfsr_a_q[WIDTH-2:0], fb_a};
            lfsr_b_d = {lfsr_b_q[WIDTH-2:0], fb_b};
            cnt_d    = cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      valid_o = (state_q == StRun);
      busy_o  = (state_q != StIdle);
      done_o  = (state_q == StDone);
      x_o     = 2'b00;
      if (valid_o) begin
         x_o = {bit_b, bit_a};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         lfsr_a_q <= SeedA;
         lfsr_b_q <= SeedB;
         val_a_q  <= '0;
         val_b_q  <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         lfsr_a_q <= lfsr_a_d;
         lfsr_b_q <= lfsr_b_d;
         val_a_q  <= val_a_d;
         val_b_q  <= val_b_d;
         cnt_q    <= cnt_d;
      end
   end

`ifdef BSTREAM_GEN_ONES_CNT_EN
   logic [LEN_W-1:0] ones_a_q, ones_a_d;
   logic [LEN_W-1:0] ones_b_q, ones_b_d;

   always_comb begin
      ones_a_d = ones_a_q;
      ones_b_d = ones_b_q;
      if ((state_q == StIdle) && start_i) begin
         ones_a_d = '0;
         ones_b_d = '0;
      end else if (state_q == StRun) begin
         ones_a_d = ones_a_q + LEN_W'(bit_a);
         ones_b_d = ones_b_q + LEN_W'(bit_b);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ones_a_q <= '0;
         ones_b_q <= '0;
      end else begin
         ones_a_q <= ones_a_d;
         ones_b_q <= ones_b_d;
      end
   end

   assign ones_a_o = ones_a_q;
   assign ones_b_o = ones_b_q;
`endif

endmodule
